demux_router: RTL and testbench
===============================

// Module: demux_router
// PURPOSE
//   Registered 1-to-NCH demultiplexer with valid/ready handshake on the input and on each output.
//   Successor to the combinational 16-way demux: width and channel count are parameters.
//   Adds per-output single-entry buffering, backpressure, a broadcast code, and out-of-range error accounting.
//   Sits between the CPU decode stage (drives fn_sel) and the function units (one output channel per unit).
// PARAMETERS
//   WIDTH     16  data width per channel, in bits
//   NCH       16  number of output channels; must satisfy NCH <= 2**SEL_W - 1
//   SEL_W     5   width of fn_sel
//   BCAST_EN  1   1: fn_sel == 2**SEL_W-1 is a broadcast to all channels; 0: that code is out-of-range
//   ERR_W     8   width of err_count
// PORTS
//   clk        in   1            clock; all state changes on the rising edge
//   rst_n      in   1            asynchronous reset, active-low
//   in_valid   in   1            input word present
//   in_ready   out  1            block can accept the input word this cycle
//   in_data    in   WIDTH        input word
//   fn_sel     in   SEL_W        destination channel; sampled together with in_data
//   out_valid  out  NCH          per-channel slot full
//   out_ready  in   NCH          per-channel consumer accepts its slot this cycle
//   out_data   out  NCH*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
//   err_pulse  out  1            one-cycle pulse: an out-of-range word was dropped
//   err_count  out  ERR_W        count of dropped words; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): out_valid=0, out_data=0, err_pulse=0, err_count=0.
//     All buffered words are discarded. Reset taken mid-transfer loses the word; there is no replay.
//   Per-channel FSM, two states:
//     EMPTY -> FULL on load.
//     FULL  -> EMPTY on out_ready with no load in the same cycle.
//     FULL  -> FULL on a load, with or without out_ready. New data replaces the old; the old word
//       counts as consumed only if out_ready was high.
//   Channel k can load this cycle iff !out_valid[k] || out_ready[k].
//   in_ready (combinational from fn_sel, out_valid, out_ready):
//     fn_sel < NCH                   : in_ready = the load condition for channel fn_sel
//     broadcast code and BCAST_EN=1  : in_ready = AND of the load conditions over all channels
//     any other code                 : in_ready = 1; the word is always accepted and dropped
//   Transfer occurs when in_valid && in_ready.
//   Unicast transfer: channel fn_sel loads in_data at the next edge (latency 1 cycle).
//     Other channels are unchanged.
//   Broadcast transfer: every channel loads in_data at the same edge. There is no partial broadcast.
//   Out-of-range transfer: no channel changes state.
//     err_pulse=1 for exactly the following cycle.
//     err_count increments, holding at 2**ERR_W-1 once reached.
//   out_data[k] holds its last loaded value after the slot drains; it clears only on reset.
//   Throughput: one word per cycle to a channel whose consumer holds out_ready high.
//   Inputs are ignored while in_valid=0; fn_sel and in_data are don't-care in that case.
//   in_data and fn_sel must stay stable while in_valid=1 && in_ready=0.
// TESTING
//   1. Reset, then send in_data=16'hA5A5, fn_sel=3, out_ready=all 1
//      -> in_ready=1; next cycle out_valid=16'h0008 and out_data[3]=16'hA5A5; the cycle after, out_valid=0.
//   2. out_ready[5]=0; send 16'h1111 then 16'h2222 to fn_sel=5
//      -> the first is accepted; in_ready=0 while holding the second.
//      -> Raise out_ready[5]: 16'h1111 drains and 16'h2222 loads on the same edge; out_valid[5] stays 1.
//   3. Send fn_sel=20 with in_valid=1, three times
//      -> in_ready=1 each time; no out_valid change; err_pulse high 3 cycles; err_count=3.
//   4. BCAST_EN=1, fn_sel=31, in_data=16'h00FF, out_ready[7]=0 and channel 7 full -> in_ready=0, nothing loads.
//      Release out_ready[7] -> all 16 channels load 16'h00FF on one edge.
//   5. ERR_W=2; send 5 out-of-range words -> err_count saturates at 3; err_pulse still fires 5 times.
//   6. Fill channels 0 and 9, then assert rst_n=0 asynchronously mid-cycle
//      -> out_valid=0 and out_data=0 immediately; after release, the block accepts a new word to fn_sel=0.

Source files
------------

// File: rtl/demux_router.sv
// demux_router: registered 1-to-NCH demux with per-channel single-entry buffers,
// valid/ready on both sides, optional broadcast code and saturating drop counter.
module demux_router #(
   parameter int WIDTH    = 16,
   parameter int NCH      = 16,
   parameter int SEL_W    = 5,
   parameter int BCAST_EN = 1,
   parameter int ERR_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     fn_sel,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic                 err_pulse,
   output logic [ERR_W-1:0]     err_count
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state [NCH];
   logic [NCH-1:0] can_load, hit, load;
   logic is_uni, is_bc, xfer, err;

   assign is_uni = fn_sel < SEL_W'(NCH);
   assign is_bc  = (BCAST_EN != 0) && (&fn_sel);

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign can_load[k]  = (state[k] == EMPTY) || out_ready[k];
      assign hit[k]       = is_uni && (fn_sel == SEL_W'(k));
      assign out_valid[k] = state[k] == FULL;
   end

   // Out-of-range codes are always accepted so a bad selector never stalls the decoder.
   assign in_ready = is_uni ? |(hit & can_load) : is_bc ? &can_load : 1'b1;
   assign xfer     = in_valid && in_ready;
   assign load     = {NCH{xfer}} & (is_bc ? {NCH{1'b1}} : hit);
   assign err      = xfer && !is_uni && !is_bc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= '{default: EMPTY};
         out_data  <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state[i] <= load[i] ? FULL : out_ready[i] ? EMPTY : state[i];
            if (load[i]) out_data[i*WIDTH +: WIDTH] <= in_data;
         end
         err_pulse <= err;
         if (err && !(&err_count)) err_count <= err_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: directed vectors for demux_router; a second instance with ERR_W=2
// shares the stimulus to exercise counter saturation.
module tb_demux_router;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [15:0]  in_data;
   logic [4:0]   fn_sel;
   logic [15:0]  out_ready;
   logic         in_ready, in_ready2;
   logic [15:0]  out_valid, out_valid2;
   logic [255:0] out_data, out_data2;
   logic         err_pulse, err_pulse2;
   logic [7:0]   err_count;
   logic [1:0]   err_count2;
   int n_cmp = 0;
   int n_err = 0;

   demux_router dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .fn_sel(fn_sel), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .err_pulse(err_pulse), .err_count(err_count)
   );

   demux_router #(.ERR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .fn_sel(fn_sel), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .err_pulse(err_pulse2), .err_count(err_count2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] dat(input int k);
      return out_data[k*16 +: 16];
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; fn_sel = '0; out_ready = '1;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_data", 64'(|out_data), 64'h0);
      check("rst_pulse", 64'(err_pulse), 64'h0);
      check("rst_count", 64'(err_count), 64'h0);

      // unicast, consumer ready
      in_valid = 1'b1; fn_sel = 5'd3; in_data = 16'hA5A5;
      #1 check("t1_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("t1_valid", 64'(out_valid), 64'h0008);
      check("t1_data3", 64'(dat(3)), 64'hA5A5);
      tick();
      check("t1_drain", 64'(out_valid), 64'h0);

      // backpressure on channel 5
      out_ready = ~16'h0020;
      in_valid = 1'b1; fn_sel = 5'd5; in_data = 16'h1111;
      #1 check("t2_ready1", 64'(in_ready), 64'h1);
      tick();
      in_data = 16'h2222;
      #1 check("t2_stall", 64'(in_ready), 64'h0);
      tick();
      check("t2_hold_v", 64'(out_valid), 64'h0020);
      check("t2_hold_d", 64'(dat(5)), 64'h1111);
      out_ready = '1;
      #1 check("t2_ready2", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("t2_swap_v", 64'(out_valid), 64'h0020);
      check("t2_swap_d", 64'(dat(5)), 64'h2222);
      tick();
      check("t2_drain", 64'(out_valid), 64'h0);

      // out-of-range, three back to back
      in_valid = 1'b1; fn_sel = 5'd20; in_data = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         #1 check("t3_ready", 64'(in_ready), 64'h1);
         tick();
         check("t3_pulse", 64'(err_pulse), 64'h1);
         check("t3_valid", 64'(out_valid), 64'h0);
      end
      in_valid = 1'b0;
      check("t3_count", 64'(err_count), 64'd3);
      check("t3_data5", 64'(dat(5)), 64'h2222);
      tick();
      check("t3_pulse_off", 64'(err_pulse), 64'h0);
      check("t3_count_hold", 64'(err_count), 64'd3);

      // broadcast blocked by a full, stalled channel 7
      out_ready = ~16'h0080;
      in_valid = 1'b1; fn_sel = 5'd7; in_data = 16'h7777;
      tick();
      fn_sel = 5'd31; in_data = 16'h00FF;
      #1 check("t4_block", 64'(in_ready), 64'h0);
      tick();
      check("t4_nopart_v", 64'(out_valid), 64'h0080);
      check("t4_nopart_d7", 64'(dat(7)), 64'h7777);
      check("t4_nopart_d0", 64'(dat(0)), 64'h0);
      check("t4_nopulse", 64'(err_pulse), 64'h0);
      out_ready = '1;
      #1 check("t4_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("t4_all_v", 64'(out_valid), 64'hFFFF);
      for (int k = 0; k < 16; k++) check($sformatf("t4_d%0d", k), 64'(dat(k)), 64'h00FF);
      check("t4_count", 64'(err_count), 64'd3);
      tick();
      check("t4_drain", 64'(out_valid), 64'h0);

      // saturation: small counter stops at 3, wide one keeps counting
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      check("t5_rst", 64'(err_count2), 64'h0);
      in_valid = 1'b1; fn_sel = 5'd17;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_pulse2", 64'(err_pulse2), 64'h1);
         check("t5_pulse", 64'(err_pulse), 64'h1);
      end
      in_valid = 1'b0;
      check("t5_sat", 64'(err_count2), 64'd3);
      check("t5_count", 64'(err_count), 64'd5);
      tick();
      check("t5_pulse_off", 64'(err_pulse2), 64'h0);
      check("t5_sat_hold", 64'(err_count2), 64'd3);

      // asynchronous reset mid-cycle
      out_ready = ~16'h0201;
      in_valid = 1'b1; fn_sel = 5'd0; in_data = 16'h1234;
      tick();
      fn_sel = 5'd9; in_data = 16'h5678;
      tick();
      in_valid = 1'b0;
      check("t6_fill_v", 64'(out_valid), 64'h0201);
      check("t6_fill_d9", 64'(dat(9)), 64'h5678);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_v", 64'(out_valid), 64'h0);
      check("t6_async_d", 64'(|out_data), 64'h0);
      check("t6_async_c", 64'(err_count), 64'h0);
      rst_n = 1'b1;
      out_ready = '1;
      in_valid = 1'b1; fn_sel = 5'd0; in_data = 16'hBEEF;
      #1 check("t6_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("t6_new_v", 64'(out_valid), 64'h0001);
      check("t6_new_d", 64'(dat(0)), 64'hBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
